// File: rtl/ibex_pkg.sv
// Shared types for the EX-stage sequencer: operation kinds, FSM states and a saturating counter helper.
package ibex_pkg;

    typedef enum logic [1:0] {
        EX_ALU    = 2'd0,
        EX_ALU_MC = 2'd1,
        EX_MUL    = 2'd2,
        EX_DIV    = 2'd3
    } ex_kind_e;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_EXEC = 2'd1,
        SEQ_HOLD = 2'd2
    } ex_seq_state_e;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/ibex_ex_seq.sv
// EX-stage sequencer: accepts one op in IDLE, drives multdiv controls during EXEC, holds the result until writeback.
// Registered state with a combinational decode; cancel and reset always discard the in-flight op.
module ibex_ex_seq
    import ibex_pkg::*;
#(
    parameter bit          RV32M     = 1'b1,
    parameter int unsigned MaxCycles = 40
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       issue_valid_i,
    input  logic [1:0] issue_kind_i,
    output logic       issue_ready_o,
    input  logic       cancel_i,
    input  logic       ex_valid_i,
    input  logic       wb_ready_i,
    output logic       mult_en_o,
    output logic       div_en_o,
    output logic       mult_sel_o,
    output logic       div_sel_o,
    output logic       alu_instr_first_cycle_o,
    output logic       multdiv_ready_id_o,
    output logic       done_o,
    output logic       illegal_o,
    output logic       timeout_o,
    output logic [5:0] cycle_count_o
);

    ex_seq_state_e state_q, state_d;
    ex_kind_e      kind_q, kind_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [5:0]    cyc_q, cyc_d;
    logic [5:0]    exec_cnt;
    ex_kind_e      issue_kind;
    logic          issue_is_md;

    assign issue_kind    = ex_kind_e'(issue_kind_i);
    assign issue_is_md   = (issue_kind == EX_MUL) || (issue_kind == EX_DIV);
    // Count including the current EXEC cycle.
    assign exec_cnt      = sat_inc6(cnt_q);
    assign cycle_count_o = cyc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SEQ_IDLE;
            kind_q  <= EX_ALU;
            cnt_q   <= 6'd0;
            cyc_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        kind_d                  = kind_q;
        cnt_d                   = cnt_q;
        cyc_d                   = cyc_q;
        issue_ready_o           = 1'b0;
        mult_en_o               = 1'b0;
        div_en_o                = 1'b0;
        mult_sel_o              = 1'b0;
        div_sel_o               = 1'b0;
        alu_instr_first_cycle_o = 1'b0;
        multdiv_ready_id_o      = 1'b0;
        done_o                  = 1'b0;
        illegal_o               = 1'b0;
        timeout_o               = 1'b0;

        unique case (state_q)
            SEQ_IDLE: begin
                issue_ready_o = 1'b1;
                if (issue_valid_i && !cancel_i) begin
                    if (issue_is_md && !RV32M) begin
                        illegal_o = 1'b1;
                    end else begin
                        kind_d  = issue_kind;
                        cnt_d   = 6'd0;
                        state_d = SEQ_EXEC;
                    end
                end
            end
            SEQ_EXEC: begin
                alu_instr_first_cycle_o = (cnt_q == 6'd0);
                if (cancel_i) begin
                    state_d = SEQ_IDLE;
                end else begin
                    mult_en_o  = (kind_q == EX_MUL);
                    mult_sel_o = (kind_q == EX_MUL);
                    div_en_o   = (kind_q == EX_DIV);
                    div_sel_o  = (kind_q == EX_DIV);
                    cnt_d      = exec_cnt;
                    if (ex_valid_i) begin
                        if (wb_ready_i) begin
                            done_o             = 1'b1;
                            multdiv_ready_id_o = 1'b1;
                            cyc_d              = exec_cnt;
                            state_d            = SEQ_IDLE;
                        end else begin
                            state_d = SEQ_HOLD;
                        end
                    end else if (exec_cnt == 6'(MaxCycles)) begin
                        timeout_o = 1'b1;
                        state_d   = SEQ_IDLE;
                    end
                end
            end
            SEQ_HOLD: begin
                if (cancel_i) begin
                    state_d = SEQ_IDLE;
                end else begin
                    mult_sel_o = (kind_q == EX_MUL);
                    div_sel_o  = (kind_q == EX_DIV);
                    if (wb_ready_i) begin
                        done_o             = 1'b1;
                        multdiv_ready_id_o = 1'b1;
                        cyc_d              = cnt_q;
                        state_d            = SEQ_IDLE;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // An op caught by reset never reports completion or errors.
        if (!rst_ni) begin
            done_o             = 1'b0;
            multdiv_ready_id_o = 1'b0;
            timeout_o          = 1'b0;
            illegal_o          = 1'b0;
        end
    end

endmodule

// File: doc/ibex_ex_seq.md
IBEX_EX_SEQ -- requirements
Module: ibex_ex_seq

Interface
REQ-001 SHALL have parameter RV32M, default 1: MUL/DIV issue permitted.
REQ-002 SHALL have parameter MaxCycles, default 40: EXEC cycle limit before timeout, range 2..63.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port issue_valid_i  in  1  operation offered.
REQ-006 SHALL have port issue_kind_i  in  2  ex_kind_e of the offered operation.
REQ-007 SHALL have port issue_ready_o  out  1  sequencer accepts an operation this cycle.
REQ-008 SHALL have port cancel_i  in  1  flush of the in-flight operation.
REQ-009 SHALL have port ex_valid_i  in  1  EX block result valid.
REQ-010 SHALL have port wb_ready_i  in  1  writeback accepts the result.
REQ-011 SHALL have ports mult_en_o, div_en_o, mult_sel_o, div_sel_o  out  1 each  multdiv controls to EX block.
REQ-012 SHALL have port alu_instr_first_cycle_o  out  1  first EXEC cycle.
REQ-013 SHALL have port multdiv_ready_id_o  out  1  result consumed, multdiv may release.
REQ-014 SHALL have port done_o  out  1  one-cycle completion pulse.
REQ-015 SHALL have ports illegal_o and timeout_o  out  1 each  one-cycle error pulses.
REQ-016 SHALL have port cycle_count_o  out  6  EXEC cycles of the last completed op, saturating.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, HOLD.
REQ-018 IDLE SHALL drive issue_ready_o=1; in EXEC and HOLD it SHALL drive issue_ready_o=0.
REQ-019 In IDLE, issue_valid_i=1 with cancel_i=0 and a legal kind SHALL latch the kind, clear the counter and enter EXEC next cycle.
REQ-020 If RV32M=0, a MUL/DIV issue SHALL pulse illegal_o in the accept cycle and the FSM SHALL stay in IDLE.
REQ-021 alu_instr_first_cycle_o SHALL be 1 only in the first EXEC cycle after accept.
REQ-022 In EXEC, mult_en_o/mult_sel_o SHALL be 1 for kind MUL and div_en_o/div_sel_o SHALL be 1 for kind DIV; all four SHALL be 0 for ALU and ALU_MC.
REQ-023 In EXEC, ex_valid_i=1 with wb_ready_i=1 SHALL assert done_o and multdiv_ready_id_o in the same cycle, and the FSM SHALL enter IDLE next cycle.
REQ-024 In EXEC, ex_valid_i=1 with wb_ready_i=0 SHALL enter HOLD.
REQ-025 HOLD SHALL keep *_sel_o, drive *_en_o=0 and multdiv_ready_id_o=0 until wb_ready_i=1, then assert done_o and multdiv_ready_id_o and return to IDLE.
REQ-026 The counter SHALL increment once per EXEC cycle.
REQ-027 On reaching MaxCycles EXEC cycles without ex_valid_i, the block SHALL pulse timeout_o, omit done_o and return to IDLE.
REQ-028 On done_o, cycle_count_o SHALL load the EXEC cycle count, including the completing cycle, saturated at 63; it SHALL otherwise hold.
REQ-029 cancel_i in EXEC or HOLD SHALL force IDLE next cycle with all *_en_o, *_sel_o, done_o and multdiv_ready_id_o at 0 in that cycle.
REQ-030 cancel_i SHALL win over a simultaneous ex_valid_i or a timeout.
REQ-031 cancel_i in IDLE SHALL block acceptance of a simultaneous issue.
REQ-032 The minimum issue-to-issue spacing SHALL be 2 cycles: an op is accepted in IDLE, completes in EXEC, and the next op is accepted in IDLE.

Reset
REQ-033 rst_ni=0 at a clock edge SHALL force IDLE, zero the counter and clear cycle_count_o.
REQ-034 A reset asserted mid-operation SHALL discard the operation without asserting done_o.
REQ-035 After reset, all outputs SHALL be 0 except issue_ready_o, which SHALL be 1.

Structure
REQ-036 ex_kind_e (ALU=0, ALU_MC=1, MUL=2, DIV=3) and ex_seq_state_e SHALL reside in ibex_pkg.
REQ-037 The block SHALL be a single module with no sub-modules, using a registered state and a combinational output decode.

Verification
REQ-038 Bench SHALL cover: ALU issue, ex_valid_i=1 on the first EXEC cycle, wb_ready_i=1 -> done_o at cycle 1 after accept, cycle_count_o=1, alu_instr_first_cycle_o=1 in that cycle.
REQ-039 Bench SHALL cover: DIV issue, ex_valid_i on the 37th EXEC cycle -> div_en_o=1 for 37 cycles, done_o, cycle_count_o=37.
REQ-040 Bench SHALL cover: MUL issue, ex_valid_i at cycle 3, wb_ready_i low 4 cycles -> HOLD for 4 cycles with mult_sel_o=1, mult_en_o=0, then done_o and multdiv_ready_id_o together.
REQ-041 Bench SHALL cover: MaxCycles=40, ALU_MC issue, ex_valid_i never asserted -> timeout_o at EXEC cycle 40, no done_o, issue_ready_o=1 next cycle.
REQ-042 Bench SHALL cover: cancel_i coincident with ex_valid_i in EXEC -> no done_o, IDLE next cycle.
REQ-043 Bench SHALL cover: RV32M=0 with a MUL issue -> illegal_o pulse, FSM stays in IDLE.
REQ-044 Bench SHALL cover: rst_ni=0 during a DIV operation -> IDLE, cycle_count_o=0.
